// File: rtl/cpu_run_pkg.sv
// Shared state encodings and constants for the CPU run controller.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TMO  = 2'd3
  } run_state_e;

  localparam logic [31:0] INSTR_SYSCALL = 32'h0000_000C;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter
  import cpu_run_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the MIPS core: reset pulse, cycle count, halt/timeout detection.
// Optional syscall-halt detection is enabled by defining CPU_RUN_CTRL_SYSCALL_HALT_EN.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 10,
  parameter int MAX_CYCLES   = 10000,
  parameter int HALT_REPEAT  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  input  logic [31:0]      instr,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int RST_W = cnt_width(RESET_CYCLES);
  localparam int REP_W = cnt_width(HALT_REPEAT);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(HALT_REPEAT - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((MAX_CYCLES > 0) ? (MAX_CYCLES - 1) : 0);
  localparam bit TMO_EN = (MAX_CYCLES != 0);

  run_state_e      state_q;
  logic            cpu_reset_q, running_q, done_q, timed_out_q;
  logic [PC_W-1:0] halt_pc_q, last_pc_q;
  logic            last_vld_q;

  logic [RST_W-1:0] rst_cnt_s;
  logic [REP_W-1:0] rep_cnt_s;
  logic [CNT_W-1:0] cycle_cnt_s;

  logic in_run_s, pc_match_s, loop_halt_s, sys_halt_s, halt_s, tmo_s, rst_done_s;

  assign in_run_s    = (state_q == ST_RUN);
  // last_vld_q keeps the first valid PC of a run from matching a stale last_pc_q.
  assign pc_match_s  = pc_valid && last_vld_q && (pc == last_pc_q);
  assign loop_halt_s = in_run_s && pc_match_s && (rep_cnt_s >= REP_LAST);
  assign tmo_s       = TMO_EN && in_run_s && (cycle_cnt_s == TMO_LAST);
  assign rst_done_s  = (state_q == ST_RST) && (rst_cnt_s == RST_LAST);
  assign halt_s      = loop_halt_s || sys_halt_s;

`ifdef CPU_RUN_CTRL_SYSCALL_HALT_EN
  assign sys_halt_s = in_run_s && pc_valid && (instr == INSTR_SYSCALL);
`else
  logic unused_instr_s;
  assign unused_instr_s = ^instr;
  assign sys_halt_s     = 1'b0;
`endif

  sat_counter #(.W(RST_W)) u_rst_cnt (
    .clk (clk),
    .clr (reset || restart),
    .inc (state_q == ST_RST),
    .cnt (rst_cnt_s)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .clr (reset || restart),
    .inc (in_run_s),
    .cnt (cycle_cnt_s)
  );

  sat_counter #(.W(REP_W)) u_rep_cnt (
    .clk (clk),
    .clr (reset || restart || (in_run_s && pc_valid && !pc_match_s)),
    .inc (in_run_s && pc_match_s),
    .cnt (rep_cnt_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RST;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      halt_pc_q   <= '0;
      last_pc_q   <= '0;
      last_vld_q  <= 1'b0;
    end else if (restart) begin
      state_q     <= ST_RST;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      last_vld_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (rst_done_s) begin
            state_q     <= ST_RUN;
            cpu_reset_q <= 1'b0;
            running_q   <= 1'b1;
          end else begin
            state_q <= ST_RST;
          end
        end
        ST_RUN: begin
          if (pc_valid) begin
            last_pc_q  <= pc;
            last_vld_q <= 1'b1;
          end
          // Halt outranks timeout when both fire on the same cycle.
          if (halt_s) begin
            state_q   <= ST_HALT;
            done_q    <= 1'b1;
            halt_pc_q <= pc;
            running_q <= 1'b0;
          end else if (tmo_s) begin
            state_q     <= ST_TMO;
            timed_out_q <= 1'b1;
            running_q   <= 1'b0;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_HALT, ST_TMO: begin
          state_q <= state_q;
        end
        default: begin
          state_q     <= ST_RST;
          cpu_reset_q <= 1'b1;
          running_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign running   = running_q;
  assign done      = done_q;
  assign timed_out = timed_out_q;
  assign cycle_cnt = cycle_cnt_s;
  assign halt_pc   = halt_pc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed, table-driven bench for cpu_run_ctrl (budgeted instance plus a no-timeout instance).
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, restart, pc_valid;
  logic [31:0] pc, instr;

  logic        a_cpu_reset, a_running, a_done, a_tmo;
  logic [31:0] a_cnt, a_hpc;
  logic        b_cpu_reset, b_running, b_done, b_tmo;
  logic [31:0] b_cnt, b_hpc;

  int checks = 0;
  int errors = 0;

  cpu_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RESET_CYCLES(10), .MAX_CYCLES(20), .HALT_REPEAT(2)
  ) u_dut (
    .clk(clk), .reset(reset), .restart(restart), .pc(pc), .pc_valid(pc_valid),
    .instr(instr), .cpu_reset(a_cpu_reset), .running(a_running), .done(a_done),
    .timed_out(a_tmo), .cycle_cnt(a_cnt), .halt_pc(a_hpc)
  );

  cpu_run_ctrl #(
    .PC_W(32), .CNT_W(32), .RESET_CYCLES(10), .MAX_CYCLES(0), .HALT_REPEAT(2)
  ) u_dut_nt (
    .clk(clk), .reset(reset), .restart(restart), .pc(pc), .pc_valid(pc_valid),
    .instr(instr), .cpu_reset(b_cpu_reset), .running(b_running), .done(b_done),
    .timed_out(b_tmo), .cycle_cnt(b_cnt), .halt_pc(b_hpc)
  );

  typedef struct {
    logic        restart;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        e_rst;
    logic        e_run;
    logic        e_done;
    logic        e_tmo;
    logic [31:0] e_cnt;
    logic [31:0] e_hpc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] p,
                              input logic [31:0] ins, input logic er, input logic eu,
                              input logic ed, input logic et, input logic [31:0] ec,
                              input logic [31:0] eh);
    vec_t x;
    x.restart = r;  x.valid = v;  x.pc = p;  x.instr = ins;
    x.e_rst = er;   x.e_run = eu; x.e_done = ed; x.e_tmo = et;
    x.e_cnt = ec;   x.e_hpc = eh;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic er, input logic eu, input logic ed,
                       input logic et, input logic [31:0] ec, input logic [31:0] eh);
    chk({tag, ".cpu_reset"}, 32'(a_cpu_reset), 32'(er));
    chk({tag, ".running"},   32'(a_running),   32'(eu));
    chk({tag, ".done"},      32'(a_done),      32'(ed));
    chk({tag, ".timed_out"}, 32'(a_tmo),       32'(et));
    chk({tag, ".cycle_cnt"}, a_cnt, ec);
    chk({tag, ".halt_pc"},   a_hpc, eh);
  endtask

  task automatic apply(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      restart  = vt[i].restart;
      pc_valid = vt[i].valid;
      pc       = vt[i].pc;
      instr    = vt[i].instr;
      step();
      chk_a($sformatf("%s[%0d]", tag, i), vt[i].e_rst, vt[i].e_run, vt[i].e_done,
            vt[i].e_tmo, vt[i].e_cnt, vt[i].e_hpc);
    end
    restart  = 1'b0;
    pc_valid = 1'b0;
    instr    = 32'h0;
  endtask

  // Expects cpu_reset already sampled high at count 0: 9 more high cycles, then RUN.
  task automatic reset_seq(input string tag);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("%s.cpu_reset%0d", tag, i), 32'(a_cpu_reset), (i < 10) ? 32'd1 : 32'd0);
      chk($sformatf("%s.running%0d", tag, i),   32'(a_running),   (i < 10) ? 32'd0 : 32'd1);
    end
    chk({tag, ".b_running"}, 32'(b_running), 32'd1);
    chk({tag, ".cycle_cnt"}, a_cnt, 32'd0);
  endtask

  task automatic do_restart(input string tag, input logic [31:0] hpc);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk_a(tag, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, hpc);
  endtask

  initial begin
    logic nt_flag_seen;
    reset = 1'b1; restart = 1'b0; pc_valid = 1'b0; pc = 32'h0; instr = 32'h0;

    // 0..5 self-loop halt, 6 restart, 7..10 invalidation + pc_valid=0, 11 restart, 12.. syscall
    vt.push_back(mk(1'b0, 1'b1, 32'h3000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'h0));
    vt.push_back(mk(1'b0, 1'b1, 32'h3004, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'h0));
    vt.push_back(mk(1'b0, 1'b1, 32'h3008, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 32'h0));
    vt.push_back(mk(1'b0, 1'b1, 32'h3008, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4, 32'h0));
    vt.push_back(mk(1'b0, 1'b1, 32'h3008, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 32'h3008));
    vt.push_back(mk(1'b0, 1'b1, 32'h4000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 32'h3008));
    vt.push_back(mk(1'b1, 1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h3008));
    vt.push_back(mk(1'b0, 1'b1, 32'h3008, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'h3008));
    vt.push_back(mk(1'b0, 1'b1, 32'h3008, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'h3008));
    vt.push_back(mk(1'b0, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 32'h3008));
    vt.push_back(mk(1'b0, 1'b1, 32'h3008, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 32'h3008));
    vt.push_back(mk(1'b1, 1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h3008));
    vt.push_back(mk(1'b0, 1'b1, 32'h300C, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'h0));
`ifdef CPU_RUN_CTRL_SYSCALL_HALT_EN
    vt.push_back(mk(1'b0, 1'b1, 32'h3010, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 32'h3010));
    vt.push_back(mk(1'b0, 1'b1, 32'h3014, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 32'h3010));
`else
    vt.push_back(mk(1'b0, 1'b1, 32'h3010, 32'hC, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'h0));
    vt.push_back(mk(1'b0, 1'b1, 32'h3014, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 32'h0));
`endif

    // Power-on reset held three cycles
    step();
    chk_a("por", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    step();
    step();
    reset = 1'b0;
    reset_seq("boot");

    apply(0, 5, "halt");

    // Restart from HALT, then restart again part-way through the reset pulse
    apply(6, 6, "restart1");
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rst_mid.cpu_reset%0d", i), 32'(a_cpu_reset), 32'd1);
    end
    apply(6, 6, "restart2");
    reset_seq("rerun");

    apply(7, 10, "inval");
    apply(11, 11, "restart3");
    reset_seq("tmo_boot");

    // Timeout after 20 RUN cycles; the unbudgeted instance keeps running
    for (int i = 1; i <= 20; i++) begin
      pc = 32'h100 + 32'(i) * 32'd4;
      pc_valid = 1'b1;
      step();
      if (i < 20) begin
        chk($sformatf("tmo.running%0d", i), 32'(a_running), 32'd1);
        chk($sformatf("tmo.timed_out%0d", i), 32'(a_tmo), 32'd0);
      end else begin
        chk_a("tmo.end", 1'b0, 1'b0, 1'b0, 1'b1, 32'd20, 32'h3008);
        chk("nt.cnt20", b_cnt, 32'd20);
        chk("nt.running20", 32'(b_running), 32'd1);
      end
    end
    nt_flag_seen = 1'b0;
    for (int i = 21; i <= 1000; i++) begin
      pc = 32'h100 + 32'(i) * 32'd4;
      step();
      if (b_done || b_tmo || !b_running) nt_flag_seen = 1'b1;
    end
    pc_valid = 1'b0;
    chk("nt.flag_seen", 32'(nt_flag_seen), 32'd0);
    chk("nt.cnt1000", b_cnt, 32'd1000);
    chk("tmo.hold_cnt", a_cnt, 32'd20);
    chk("tmo.hold_flag", 32'(a_tmo), 32'd1);

    // Halt and timeout on the same cycle: halt wins
    do_restart("restart4", 32'h3008);
    reset_seq("both_boot");
    for (int i = 1; i <= 20; i++) begin
      pc = (i <= 17) ? (32'h200 + 32'(i) * 32'd4) : 32'h7000;
      pc_valid = 1'b1;
      step();
      if (i == 19) chk_a("both.c19", 1'b0, 1'b1, 1'b0, 1'b0, 32'd19, 32'h3008);
    end
    pc_valid = 1'b0;
    chk_a("both.end", 1'b0, 1'b0, 1'b1, 1'b0, 32'd20, 32'h7000);
    chk("both.nt_done", 32'(b_done), 32'd1);

    // Reset asserted mid-RUN clears everything, including halt_pc
    do_restart("restart5", 32'h7000);
    reset_seq("mid_boot");
    for (int i = 1; i <= 3; i++) begin
      pc = 32'h500 + 32'(i) * 32'd4;
      pc_valid = 1'b1;
      step();
    end
    chk("mid.cnt3", a_cnt, 32'd3);
    reset = 1'b1;
    pc_valid = 1'b0;
    step();
    chk_a("mid.reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    reset = 1'b0;
    reset_seq("sys_boot");

    apply(12, 14, "syscall");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable run controller for the MIPS core.
- Generates the core reset pulse with a parametrised length and counts executed cycles.
- Detects program halt, defined as the PC stuck on a self-loop, and flags timeout after a configurable cycle budget.
- Sits beside the mips top; replaces hand-timed reset/finish delays with cycle-exact, restartable control and status outputs.

Parameters:
PC_W, 32, width of monitored PC
CNT_W, 32, width of cycle counter
RESET_CYCLES, 10, cycles cpu_reset held high per run (>=1)
MAX_CYCLES, 10000, run-cycle budget; 0 disables timeout
HALT_REPEAT, 2, consecutive valid cycles with unchanged PC that declare halt (>=1)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high; controller reset
restart  in  1  single-cycle pulse; begin a new run
pc  in  PC_W  core PC this cycle
pc_valid  in  1  pc is meaningful this cycle
instr  in  32  instruction at pc (used only with optional feature)
cpu_reset  out  1  reset to core, synchronous active-high
running  out  1  high in RUN state
done  out  1  sticky: run ended by halt
timed_out  out  1  sticky: run ended by budget exhaustion
cycle_cnt  out  CNT_W  RUN-state cycles this run, saturating
halt_pc  out  PC_W  PC at which halt was declared

Behaviour:
- States: RST (cpu_reset=1), RUN, HALT, TMO. All outputs registered.
- reset=1 at an edge: state<=RST, rst_cnt<=0, cycle_cnt<=0, rep_cnt<=0, last_pc<=0, halt_pc<=0, done<=0, timed_out<=0, cpu_reset<=1, running<=0. reset overrides restart and all monitoring.
- RST: rst_cnt increments each cycle. When rst_cnt==RESET_CYCLES-1, next state is RUN. cpu_reset is high for exactly RESET_CYCLES cycles after reset deasserts.
- RUN: cycle_cnt increments every cycle and saturates at all-ones.
  - On pc_valid, if pc==last_pc, rep_cnt increments (saturating); otherwise rep_cnt<=0. last_pc<=pc.
  - First valid cycle after RST never matches, because last_pc is invalidated on entry.
- Halt: rep_cnt reaches HALT_REPEAT in RUN. Next cycle: state HALT, done=1, halt_pc=pc, running=0. cycle_cnt freezes; the halting cycle is counted.
- Timeout: MAX_CYCLES!=0 and cycle_cnt==MAX_CYCLES-1 in RUN. Next cycle: TMO, timed_out=1, cycle_cnt=MAX_CYCLES.
- Halt and timeout on the same cycle: halt wins; done=1, timed_out=0.
- HALT/TMO: core is not reset (cpu_reset=0) and status holds.
- restart in any state (reset low): next state RST. Clears done, timed_out, cycle_cnt, rep_cnt, rst_cnt; halt_pc retained. A restart while in RST restarts the reset count.
- pc_valid=0 cycles neither advance nor clear rep_cnt, but are counted in cycle_cnt.

Optional Feature:
- Macro: CPU_RUN_CTRL_SYSCALL_HALT_EN.
- Defined: in RUN, pc_valid with instr==32'h0000000C (syscall) declares halt immediately, with the same priority as the self-loop halt and halt_pc=pc.
- Undefined: instr is ignored; only self-loop and timeout end a run.

Decomposition:
- Shared package/header cpu_run_pkg holds:
  - state encodings ST_RST=2'd0, ST_RUN=2'd1, ST_HALT=2'd2, ST_TMO=2'd3
  - INSTR_SYSCALL=32'h0000000C
- One sub-module is natural: sat_counter (param W; inc, clr; saturating count out). It is instantiated for cycle_cnt, rst_cnt and rep_cnt.

Test Plan:
- RESET_CYCLES=10, reset high 3 cycles then low → cpu_reset high exactly 10 cycles after deassert; running rises on cycle 11.
- PC sequence 0x3000,0x3004,0x3008,0x3008,0x3008, HALT_REPEAT=2 → done=1 one cycle after the third 0x3008, halt_pc=0x3008, cycle_cnt=5, timed_out=0.
- MAX_CYCLES=20, PC strictly incrementing → timed_out=1 after 20 RUN cycles, cycle_cnt=20, done=0; MAX_CYCLES=0 with the same stimulus runs 1000 cycles with no flags.
- Halt condition met on cycle 20 with MAX_CYCLES=20 → done=1, timed_out=0.
- After done, pulse restart → done=0, cycle_cnt=0, cpu_reset high 10 cycles, halt_pc unchanged; reset asserted mid-RUN → RST with all counters zero next cycle.
- With CPU_RUN_CTRL_SYSCALL_HALT_EN, instr=0x0000000C at pc=0x3010 → done=1 next cycle, halt_pc=0x3010; without the macro → no halt.
